// File: rtl/cache_mem_responder_pkg.sv
// Shared types and defaults for the cache memory responder.
package cache_mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    localparam logic [31:0] CachedBaseDefault = 32'h8000_0000;
    localparam logic [31:0] CachedLenDefault  = 32'h4000_0000;

endpackage

// File: rtl/cache_mem_responder.sv
// Cache-side memory responder: accepts one request, fetches a line (or a single
// beat, or performs a store) one memory beat at a time, then returns a response.
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned LineWidth  = 128,
    parameter int unsigned TidWidth   = 2,
    parameter logic [31:0] CachedBase = CachedBaseDefault,
    parameter logic [31:0] CachedLen  = CachedLenDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic                   req_nc_i,
    input  logic [TidWidth-1:0]    req_tid_i,
    input  logic [31:0]            req_addr_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_be_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_we_o,
    output logic [TidWidth-1:0]    rsp_tid_o,
    output logic                   rsp_err_o,
    output logic [LineWidth-1:0]   rsp_data_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [31:0]            mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned NumBeats  = LineWidth / DataWidth;
    localparam int unsigned BeatW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int unsigned BeWidth   = DataWidth / 8;
    localparam logic [31:0] BeatBytes = 32'(DataWidth / 8);
    localparam logic [31:0] LineMask  = ~(32'(LineWidth / 8) - 32'd1);
    localparam logic [31:0] BeatMask  = ~(BeatBytes - 32'd1);

    state_e                 state_q, state_d;
    logic [BeatW-1:0]       beat_q, beat_d;
    logic [LineWidth-1:0]   line_q, line_d;
    logic                   we_q, we_d;
    logic                   nc_q, nc_d;
    logic                   err_q, err_d;
    logic                   drop_q, drop_d;
    logic [TidWidth-1:0]    tid_q, tid_d;
    logic [31:0]            addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [BeWidth-1:0]     be_q, be_d;

    logic        hit, miss, rvalid_ok, last_beat;
    logic [32:0] region_lo, region_hi, req_addr33;

    // Region bounds in 33 bits so a region ending at 2^32 does not wrap.
    assign region_lo  = {1'b0, CachedBase};
    assign region_hi  = {1'b0, CachedBase} + {1'b0, CachedLen};
    assign req_addr33 = {1'b0, req_addr_i};
    assign hit        = (req_addr33 >= region_lo) && (req_addr33 < region_hi);
    assign miss       = !req_we_i && !req_nc_i && !hit;

    // A beat returned after a reset hit WAIT belongs to the abandoned request.
    assign rvalid_ok  = (state_q == StWait) && !we_q && mem_rvalid_i && !drop_q;
    assign last_beat  = nc_q || (beat_q == BeatW'(NumBeats - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) state_d = miss ? StResp : StIssue;
            end
            StIssue: begin
                if (mem_gnt_i) state_d = StWait;
            end
            StWait: begin
                if (we_q) begin
                    state_d = StResp;
                end else if (rvalid_ok) begin
                    state_d = last_beat ? StResp : StIssue;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: request capture and line assembly.
    always_comb begin
        beat_d  = beat_q;
        line_d  = line_q;
        we_d    = we_q;
        nc_d    = nc_q;
        err_d   = err_q;
        tid_d   = tid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        drop_d  = drop_q && !mem_rvalid_i;
        if (state_q == StIdle && req_valid_i) begin
            beat_d  = '0;
            line_d  = '0;
            we_d    = req_we_i;
            nc_d    = req_nc_i;
            err_d   = miss;
            tid_d   = req_tid_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            be_d    = req_be_i;
        end else if (rvalid_ok) begin
            line_d[int'(beat_q)*DataWidth +: DataWidth] = mem_rdata_i;
            if (!last_beat) beat_d = beat_q + BeatW'(1);
        end
    end

    // Datapath registers; drop flag survives reset so a late beat is discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q  <= '0;
            line_q  <= '0;
            we_q    <= 1'b0;
            nc_q    <= 1'b0;
            err_q   <= 1'b0;
            tid_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            drop_q  <= drop_q || (state_q == StWait && !we_q);
        end else begin
            beat_q  <= beat_d;
            line_q  <= line_d;
            we_q    <= we_d;
            nc_q    <= nc_d;
            err_q   <= err_d;
            tid_q   <= tid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs, each driven only in the state that owns it and zero otherwise.
    always_comb begin
        req_ready_o = (state_q == StIdle);
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        rsp_valid_o = 1'b0;
        rsp_we_o    = 1'b0;
        rsp_tid_o   = '0;
        rsp_err_o   = 1'b0;
        rsp_data_o  = '0;
        if (state_q == StIssue) begin
            mem_req_o = 1'b1;
            mem_we_o  = we_q;
            if (we_q || nc_q) begin
                mem_addr_o = addr_q & BeatMask;
            end else begin
                mem_addr_o = (addr_q & LineMask) + 32'(beat_q) * BeatBytes;
            end
            mem_wdata_o = we_q ? wdata_q : '0;
            mem_be_o    = we_q ? be_q : '1;
        end
        if (state_q == StResp) begin
            rsp_valid_o = 1'b1;
            rsp_we_o    = we_q;
            rsp_tid_o   = tid_q;
            rsp_err_o   = err_q;
            rsp_data_o  = line_q;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder with an auto-responding memory model
// and hand-driven memory sequences for the reset-in-WAIT cases.
module tb_cache_mem_responder;

    typedef struct packed {
        logic         we;
        logic [1:0]   tid;
        logic         err;
        logic [127:0] data;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } beat_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i, req_ready_o, req_we_i, req_nc_i;
    logic [1:0]   req_tid_i;
    logic [31:0]  req_addr_i;
    logic [63:0]  req_wdata_i;
    logic [7:0]   req_be_i;
    logic         rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_err_o;
    logic [1:0]   rsp_tid_o;
    logic [127:0] rsp_data_o;
    logic         mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [31:0]  mem_addr_o;
    logic [63:0]  mem_wdata_o, mem_rdata_i;
    logic [7:0]   mem_be_o;

    logic         mem_auto = 1'b1;
    logic         auto_gnt, auto_rvalid, man_gnt, man_rvalid;
    logic [63:0]  auto_rdata, man_rdata;
    int           gnt_delay = 0;

    rsp_t         exp_rsp_q[$];
    beat_t        exp_beat_q[$];
    logic [63:0]  rdata_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    assign mem_gnt_i    = mem_auto ? auto_gnt : man_gnt;
    assign mem_rvalid_i = mem_auto ? auto_rvalid : man_rvalid;
    assign mem_rdata_i  = mem_auto ? auto_rdata : man_rdata;

    always #5 clk_i = ~clk_i;

    cache_mem_responder dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_nc_i     (req_nc_i),
        .req_tid_i    (req_tid_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_be_i     (req_be_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_we_o     (rsp_we_o),
        .rsp_tid_o    (rsp_tid_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_data_o   (rsp_data_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: pushes expected beats, read data and the response, then drives the request.
    task automatic send(input logic we, input logic nc, input logic [1:0] tid,
                        input logic [31:0] addr, input logic [63:0] wdata, input logic [7:0] be,
                        input logic [63:0] d0, input logic [63:0] d1);
        rsp_t        r;
        beat_t       b;
        logic [32:0] a33;
        logic        hit;
        int          k;
        a33 = {1'b0, addr};
        hit = (a33 >= 33'h0_8000_0000) && (a33 < 33'h0_C000_0000);
        r.we = we; r.tid = tid; r.err = 1'b0; r.data = '0;
        b.we = we; b.be = 8'hFF; b.wdata = '0; b.addr = {addr[31:3], 3'b000};
        if (we) begin
            b.be = be; b.wdata = wdata;
            exp_beat_q.push_back(b);
        end else if (nc) begin
            exp_beat_q.push_back(b);
            rdata_q.push_back(d0);
            r.data = {64'h0, d0};
        end else if (hit) begin
            b.addr = {addr[31:4], 4'h0};
            exp_beat_q.push_back(b);
            b.addr = {addr[31:4], 4'h0} + 32'd8;
            exp_beat_q.push_back(b);
            rdata_q.push_back(d0);
            rdata_q.push_back(d1);
            r.data = {d1, d0};
        end else begin
            r.err = 1'b1;
        end
        exp_rsp_q.push_back(r);
        req_we_i = we; req_nc_i = nc; req_tid_i = tid; req_addr_i = addr;
        req_wdata_i = wdata; req_be_i = be; req_valid_i = 1'b1;
        k = 0;
        while (!req_ready_o && k < 200) begin
            cyc();
            k++;
        end
        check_eq("req_accept", req_ready_o, 1);
        cyc();
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_rsp_q.size() != 0 && k < 500) begin
            cyc();
            k++;
        end
        check_eq("drain_rsp", exp_rsp_q.size(), 0);
    endtask

    // Response monitor: compares each handshaken response with the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            check_eq("rsp_expected", exp_rsp_q.size() != 0, 1);
            if (exp_rsp_q.size() != 0) begin
                rsp_t e;
                e = exp_rsp_q.pop_front();
                check_eq("rsp_we", rsp_we_o, e.we);
                check_eq("rsp_tid", rsp_tid_o, e.tid);
                check_eq("rsp_err", rsp_err_o, e.err);
                check_eq("rsp_data", rsp_data_o, e.data);
            end
        end
    end

    // Memory model: checks every requested beat every cycle, grants after gnt_delay,
    // returns read data on the cycle after the grant is seen.
    initial begin
        logic rv_pend;
        int   gcnt;
        beat_t b;
        auto_gnt = 1'b0; auto_rvalid = 1'b0; auto_rdata = '0;
        rv_pend = 1'b0; gcnt = 0;
        forever begin
            cyc();
            auto_gnt = 1'b0;
            auto_rvalid = 1'b0;
            if (!mem_auto) begin
                rv_pend = 1'b0;
                gcnt = 0;
            end else begin
                if (rv_pend) begin
                    auto_rvalid = 1'b1;
                    auto_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
                    rv_pend = 1'b0;
                end
                if (mem_req_o) begin
                    check_eq("mem_req_expected", exp_beat_q.size() != 0, 1);
                    if (exp_beat_q.size() != 0) begin
                        b = exp_beat_q[0];
                        check_eq("mem_addr", mem_addr_o, b.addr);
                        check_eq("mem_we", mem_we_o, b.we);
                        check_eq("mem_be", mem_be_o, b.be);
                        if (b.we) check_eq("mem_wdata", mem_wdata_o, b.wdata);
                        if (gcnt >= gnt_delay) begin
                            auto_gnt = 1'b1;
                            gcnt = 0;
                            void'(exp_beat_q.pop_front());
                            if (!b.we) rv_pend = 1'b1;
                        end else begin
                            gcnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_nc_i = 1'b0; req_tid_i = '0;
        req_addr_i = '0; req_wdata_i = '0; req_be_i = '0; rsp_ready_i = 1'b1;
        man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        repeat (3) cyc();
        rst_i = 1'b0;
        cyc();
        check_eq("rst_req_ready", req_ready_o, 1);
        check_eq("rst_rsp_valid", rsp_valid_o, 0);
        check_eq("rst_mem_req", mem_req_o, 0);
        check_eq("rst_mem_addr", mem_addr_o, 0);
        check_eq("rst_rsp_data", rsp_data_o, 0);

        // Two-beat cached line read.
        send(0, 0, 2'd2, 32'h8000_0014, '0, 8'hFF, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
        drain();

        // Store with delayed grant.
        gnt_delay = 3;
        send(1, 0, 2'd1, 32'h8000_0008, 64'hA5A5_0000_5A5A_FFFF, 8'h0F, '0, '0);
        drain();
        gnt_delay = 0;

        // Cached read outside the region: error without touching memory.
        send(0, 0, 2'd3, 32'hC000_0000, '0, 8'hFF, '0, '0);
        cnt = 0;
        while (!rsp_valid_o && cnt < 5) begin
            cyc();
            cnt++;
        end
        check_eq("miss_latency", cnt <= 1, 1);
        drain();

        // Non-cacheable single beat.
        send(0, 1, 2'd0, 32'h0001_0004, '0, 8'hFF, 64'h0BAD_CAFE_1234_5678, '0);
        drain();

        // Region boundaries.
        send(0, 0, 2'd1, 32'hBFFF_FFF8, '0, 8'hFF, 64'h4444_0000_0000_0004, 64'h5555_0000_0000_0005);
        send(0, 0, 2'd2, 32'h7FFF_FFF8, '0, 8'hFF, '0, '0);
        send(0, 0, 2'd3, 32'h8000_0000, '0, 8'hFF, 64'h6666_0000_0000_0006, 64'h7777_0000_0000_0007);
        drain();

        // Mixed traffic.
        for (int i = 0; i < 8; i++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            gnt_delay = int'($urandom_range(0, 2));
            a = (kind == 3) ? $urandom() : (32'h8000_0000 | ($urandom() & 32'h3FFF_FFFF));
            send(kind == 0, kind == 1, 2'(i), a, {$urandom(), $urandom()}, 8'($urandom()),
                 {$urandom(), $urandom()}, {$urandom(), $urandom()});
            drain();
        end
        gnt_delay = 0;

        // Response back-pressure.
        rsp_ready_i = 1'b0;
        send(0, 0, 2'd1, 32'h8000_0200, '0, 8'hFF, 64'h8888_8888_0000_0001, 64'h9999_9999_0000_0002);
        cnt = 0;
        while (!rsp_valid_o && cnt < 50) begin
            cyc();
            cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", rsp_valid_o, 1);
            check_eq("hold_data", rsp_data_o, {64'h9999_9999_0000_0002, 64'h8888_8888_0000_0001});
            check_eq("hold_tid", rsp_tid_o, 1);
            check_eq("hold_req_ready", req_ready_o, 0);
            cyc();
        end
        rsp_ready_i = 1'b1;
        drain();

        // Reset in WAIT, stale beat one cycle after reset.
        mem_auto = 1'b0;
        req_we_i = 1'b0; req_nc_i = 1'b0; req_tid_i = 2'd2; req_addr_i = 32'h8000_0040;
        req_be_i = 8'hFF; req_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        check_eq("a_mem_req", mem_req_o, 1);
        man_gnt = 1'b1;
        cyc();
        man_gnt = 1'b0;
        check_eq("a_wait_no_req", mem_req_o, 0);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        man_rvalid = 1'b1; man_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        check_eq("a_idle_ready", req_ready_o, 1);
        check_eq("a_no_rsp", rsp_valid_o, 0);
        cyc();
        man_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("a_quiet_rsp", rsp_valid_o, 0);
            check_eq("a_quiet_req", mem_req_o, 0);
            cyc();
        end

        // Reset in WAIT, stale beat landing in the next request's WAIT.
        req_tid_i = 2'd3; req_addr_i = 32'h8000_0100; req_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        man_gnt = 1'b1;
        cyc();
        man_gnt = 1'b0;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        begin
            rsp_t r;
            r.we = 1'b0; r.tid = 2'd1; r.err = 1'b0; r.data = {64'h0, 64'h3333_4444_5555_6666};
            exp_rsp_q.push_back(r);
        end
        req_nc_i = 1'b1; req_tid_i = 2'd1; req_addr_i = 32'h0000_200C; req_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        req_nc_i = 1'b0;
        check_eq("b_mem_req", mem_req_o, 1);
        check_eq("b_mem_addr", mem_addr_o, 32'h0000_2008);
        check_eq("b_mem_be", mem_be_o, 8'hFF);
        man_gnt = 1'b1;
        cyc();
        man_gnt = 1'b0;
        man_rvalid = 1'b1; man_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        cyc();
        man_rdata = 64'h3333_4444_5555_6666;
        cyc();
        man_rvalid = 1'b0;
        drain();
        mem_auto = 1'b1;

        // Normal service after the aborted transactions.
        send(0, 0, 2'd0, 32'h9000_0028, '0, 8'hFF, 64'hABCD_0000_0000_0001, 64'hABCD_0000_0000_0002);
        drain();
        check_eq("beats_consumed", exp_beat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
